// File: rtl/wave_pwm_out.sv
// rtl/wave_pwm_out.sv - sample conditioning (gain/offset/clamp) and PWM carrier output stage
module wave_pwm_out #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         sample_in,
  input  logic [7:0]         gain,
  input  logic [8:0]         offset,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               sat_clr,
  output logic               pwm_out,
  output logic               period_start,
  output logic [7:0]         cur_level,
  output logic               sat_flag
);

  logic [15:0]        prod;
  logic [7:0]         level_next;
  logic               clamp_next;
  logic signed [10:0] sum;
  logic [7:0]         sum_level;
  logic               sum_clamp;
  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         carrier;
  logic               tick;
  logic               boundary;
  logic [7:0]         carrier_d;
  logic [7:0]         level_d;

  // Gain/128 plus signed offset, clamped to the 8-bit level range
  always_comb begin
    sum       = $signed({2'b00, prod[15:7]}) + $signed({{2{offset[8]}}, offset});
    sum_level = sum[7:0];
    sum_clamp = 1'b0;
    if (sum < 11'sd0) begin
      sum_level = 8'd0;
      sum_clamp = 1'b1;
    end else if (sum > 11'sd255) begin
      sum_level = 8'd255;
      sum_clamp = 1'b1;
    end
  end

  // Two-stage conditioning pipeline, free-running regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= 16'd0;
      level_next <= 8'd0;
      clamp_next <= 1'b0;
    end else begin
      prod       <= {8'd0, sample_in} * {8'd0, gain};
      level_next <= sum_level;
      clamp_next <= sum_clamp;
    end
  end

  // Carrier tick / period boundary decode and the values loaded this edge
  always_comb begin
    tick     = (presc_cnt >= prescale);
    boundary = enable && tick && (carrier == 8'hFF);
    carrier_d = carrier;
    if (!enable) begin
      carrier_d = 8'hFF;
    end else if (tick) begin
      carrier_d = carrier + 8'd1;
    end
    level_d = boundary ? level_next : cur_level;
  end

  // Prescaler and carrier counter; parked at end-of-period while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      carrier   <= 8'hFF;
    end else begin
      carrier <= carrier_d;
      if (!enable || tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Level latch at boundaries and registered pin drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_level    <= 8'd0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      cur_level    <= level_d;
      period_start <= boundary;
      pwm_out      <= enable && (carrier_d < level_d);
    end
  end

  // Sticky saturation flag; a new clamp wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (boundary && clamp_next) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: doc/wave_pwm_out.md
# wave_pwm_out

Output stage downstream of the function generator. Takes the 8-bit waveform sample, applies unsigned gain and signed offset with saturation, and drives a single-pin PWM carrier whose duty tracks the conditioned level. The duty level changes only at carrier-period boundaries. The pin feeds an external RC filter to reconstruct the analog waveform.

## Interface
- PRESC_W, default 16: width of the carrier prescaler.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run PWM carrier; low = output parked low.
- sample_in  in  8  unsigned waveform sample (function generator signal_waveform).
- gain  in  8  unsigned gain, value/128 (128 = unity, 255 ≈ 1.99).
- offset  in  9  signed two's-complement offset added after gain (−256..+255).
- prescale  in  PRESC_W  carrier tick every prescale+1 clocks.
- sat_clr  in  1  clears sat_flag.
- pwm_out  out  1  registered PWM pin.
- period_start  out  1  one-clock pulse marking the first clock of each carrier period.
- cur_level  out  8  level in force for the current carrier period.
- sat_flag  out  1  sticky flag: a clamped level was latched.

## Operation
- Conditioning pipeline runs every clock, independent of enable:
  - Stage 1: prod <= sample_in * gain (16 b unsigned).
  - Stage 2: sum = (prod >> 7) + sign-extended offset, evaluated in 11-bit signed.
  - Stage 2 clamp: level_next <= 0 if sum < 0, 255 if sum > 255, else sum[7:0]. clamp_next <= 1 when either limit applies.
- Prescaler presc_cnt:
  - tick = (presc_cnt >= prescale).
  - On tick, presc_cnt <= 0; otherwise presc_cnt increments.
  - Using >= makes a prescale reduction mid-count take effect immediately.
- Carrier: 8-bit counter, increments on tick, wraps 255 -> 0.
- Period boundary (tick && carrier == 255):
  - carrier <= 0; cur_level <= level_next; period_start <= 1.
  - If clamp_next, sat_flag <= 1.
- period_start <= 0 on all other clocks.
- pwm_out <= enable && (carrier' < cur_level'), where primes denote the values being loaded this edge.
  - Level 0: constantly low.
  - Level 255: high 255 of 256 steps. No 100 % duty.
- enable low (synchronous):
  - presc_cnt <= 0; carrier <= 255; pwm_out <= 0; period_start <= 0.
  - cur_level and sat_flag are held.
  - Consequence: the first tick after enable rises starts a fresh period with a freshly latched level.
- sat_flag:
  - sat_clr clears it.
  - Set and clear in the same clock: set wins.

## Timing
- Reset values: pwm_out 0, period_start 0, cur_level 0, sat_flag 0, carrier 255, presc_cnt 0, pipeline registers 0.
- Latency:
  - sample_in to level_next: 2 clocks.
  - level_next to cur_level: next period boundary.
- Carrier period: 256*(prescale+1) clocks.
- High time: cur_level*(prescale+1) clocks, beginning on the period_start clock.
- First period after enable rises: boundary on the (prescale+1)-th clock with enable high.
- Inputs gain, offset, sample_in: may change any clock; they affect only levels latched at later boundaries.
- Input prescale: may change any clock, with immediate effect per the >= rule.
- Reset asserted mid-period: all state returns to reset values immediately, regardless of clk. Operation restarts as for an enable rise.

## Test plan
- Unity, prescale 0:
  - Stimulus: gain=128, offset=0, prescale=0, sample_in=64, enable=1.
  - Response: period_start every 256 clocks; pwm_out high exactly 64 consecutive clocks per period; cur_level=64; sat_flag=0.
- Saturation and sticky flag:
  - Stimulus (high clamp): sample_in=200, gain=255, i.e. 51000>>7 = 398. Response: cur_level=255 and sat_flag=1 at the next boundary.
  - Stimulus (low clamp): gain=128, offset=−20, sample_in=10. Response: cur_level=0; pwm_out constantly low.
  - Stimulus: sat_clr pulsed on a boundary clock that latches a clamped level. Response: sat_flag stays 1.
- Prescale 3:
  - Stimulus: level 100.
  - Response: period 1024 clocks; high time 400 clocks.
  - Then change prescale to 0 mid-count with presc_cnt=2. Response: tick on the next clock.
- Mid-period update:
  - Stimulus: sample_in changes 64 -> 192 at carrier 10.
  - Response: current period keeps 64 high clocks; the next period after period_start shows 192.
- Enable and reset:
  - Stimulus: enable low mid-period. Response: pwm_out=0 next clock; cur_level held.
  - Stimulus: enable high with prescale=0. Response: period_start on the 1st enabled clock, with the new level.
  - Stimulus: rst_n low between clock edges. Response: outputs 0 immediately; restart matches the post-reset enable behaviour.
